// File: rtl/note_judge_if.sv
// note_judge_if: chart/button inputs and scoring outputs of the note judge.
// master = chart reader / button side, slave = note_judge.
interface note_judge_if;
    logic        clear;
    logic        note_tick;
    logic [7:0]  note;
    logic        note_valid;
    logic [3:0]  btn_n;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;

    modport master (
        output clear, note_tick, note, note_valid, btn_n,
        input  score, streak, multiplier, hit_pulse, miss_pulse
    );

    modport slave (
        input  clear, note_tick, note, note_valid, btn_n,
        output score, streak, multiplier, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/note_judge.sv
// note_judge: tracks chart notes per lane, judges button presses as hits or
// strays, flags unplayed notes as misses, and keeps score/streak/multiplier.
// Lane index: 3 = green, 2 = yellow, 1 = blue, 0 = orange.
// Optional build macro NOTE_JUDGE_STRAY_PENALTY_EN: a stray press breaks the
// streak and raises miss_pulse for its lane.
module note_judge #(
    parameter int LEAD_ROWS   = 8,
    parameter int HIT_WINDOW  = 3,
    parameter int HIT_POINTS  = 10,
    parameter int STREAK_STEP = 10,
    parameter int MAX_MULT    = 4
) (
    input logic         CLK,
    input logic         RESET_N,
    note_judge_if.slave bus
);
    localparam int D = LEAD_ROWS + HIT_WINDOW;

    logic [3:0]        sync1, sync2, sync3;
    logic [3:0]        press;
    logic [3:0][D-1:0] pipe, pipe_nxt;
    logic [3:0]        lane_hit, lane_miss, lane_bad;

    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  mult;
    logic [3:0]  hit_q, miss_q;

    logic [2:0]  hits;
    logic [7:0]  base;
    logic [17:0] score_sum, streak_sum;
    logic [15:0] score_nxt;
    logic [7:0]  streak_nxt;

    // Falling edge of the synchronized (active-low) button is a press
    assign press = sync3 & ~sync2;

    function automatic logic [2:0] mult_of(input logic [7:0] s);
        logic [8:0] m;
        m = 9'd1 + 9'(s / 8'(STREAK_STEP));
        return (m > 9'(MAX_MULT)) ? 3'(MAX_MULT) : m[2:0];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic         found;
        logic [D-1:0] kept;

        // A press removes the oldest note in the strike zone (highest index)
        always_comb begin
            found = 1'b0;
            kept  = pipe[g];
            for (int i = D - 1; i >= LEAD_ROWS; i--) begin
                if (press[g] && !found && pipe[g][i]) begin
                    kept[i] = 1'b0;
                    found   = 1'b1;
                end
            end
        end

        // Shift is applied after the hit clear, so a hit note can never exit as a miss
        assign lane_hit[g]  = found;
        assign lane_miss[g] = bus.note_tick && kept[D-1];
        assign pipe_nxt[g]  = bus.note_tick
                            ? {kept[D-2:0], bus.note_valid && (bus.note[2*g+1 -: 2] != 2'b00)}
                            : kept;
`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
        assign lane_bad[g] = lane_miss[g] | (press[g] & ~found);
`else
        assign lane_bad[g] = lane_miss[g];
`endif
    end

    // Any miss zeroes the streak before this cycle's hits are scored
    always_comb begin
        hits       = 3'(lane_hit[0]) + 3'(lane_hit[1]) + 3'(lane_hit[2]) + 3'(lane_hit[3]);
        base       = (|lane_bad) ? 8'd0 : streak;
        score_sum  = 18'(score) + 18'(hits) * 18'(HIT_POINTS) * 18'(mult_of(base));
        streak_sum = 18'(base) + 18'(hits);
        score_nxt  = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
        streak_nxt = (streak_sum > 18'd255) ? 8'hFF : streak_sum[7:0];
    end

    // Synchronizers, lane pipes and registered outputs; clear behaves as reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1  <= 4'hF;
            sync2  <= 4'hF;
            sync3  <= 4'hF;
            pipe   <= '0;
            score  <= 16'd0;
            streak <= 8'd0;
            mult   <= 3'd1;
            hit_q  <= 4'h0;
            miss_q <= 4'h0;
        end else if (bus.clear) begin
            sync1  <= 4'hF;
            sync2  <= 4'hF;
            sync3  <= 4'hF;
            pipe   <= '0;
            score  <= 16'd0;
            streak <= 8'd0;
            mult   <= 3'd1;
            hit_q  <= 4'h0;
            miss_q <= 4'h0;
        end else begin
            sync1  <= bus.btn_n;
            sync2  <= sync1;
            sync3  <= sync2;
            pipe   <= pipe_nxt;
            score  <= score_nxt;
            streak <= streak_nxt;
            mult   <= mult_of(streak_nxt);
            hit_q  <= lane_hit;
            miss_q <= lane_bad;
        end
    end

    assign bus.score      = score;
    assign bus.streak     = streak;
    assign bus.multiplier = mult;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: scenario tasks push expected pulse events to a scoreboard
// queue; a checker pops and compares whenever the DUT raises a pulse.
module tb_note_judge;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    note_judge_if bus();

    note_judge dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [15:0] score;
        logic [7:0]  streak;
        logic [2:0]  mult;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    bit   drv_done = 1'b0;
    int   budget   = 20000;
    int   m_score  = 0;
    int   m_streak = 0;

    // One chart row strobe
    task automatic tick(input logic valid, input logic [7:0] row);
        @(negedge clk);
        bus.note_tick  = 1'b1;
        bus.note_valid = valid;
        bus.note       = row;
        @(negedge clk);
        bus.note_tick  = 1'b0;
        bus.note_valid = 1'b0;
        bus.note       = 8'h00;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    // Press lanes in mask; judged two edges later, optionally together with a tick
    task automatic press(input logic [3:0] m, input logic with_tick);
        @(negedge clk);
        bus.btn_n = ~m;
        @(negedge clk);
        @(negedge clk);
        bus.note_tick = with_tick;
        @(negedge clk);
        bus.note_tick = 1'b0;
        bus.btn_n     = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.clear      = 1'b0;
        bus.note_tick  = 1'b0;
        bus.note       = 8'h00;
        bus.note_valid = 1'b0;
        bus.btn_n      = 4'hF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.score, bus.streak, bus.multiplier, bus.hit_pulse, bus.miss_pulse} !==
            {16'd0, 8'd0, 3'd1, 4'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_state got score=%0d streak=%0d mult=%0d hit=%b miss=%b want 0/0/1/0/0",
                     bus.score, bus.streak, bus.multiplier, bus.hit_pulse, bus.miss_pulse);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        tick(1'b1, 8'hC0);
        ticks(8);
        sb.push_back('{4'b1000, 4'b0000, 16'd10, 8'd1, 3'd1});
        press(4'b1000, 1'b0);
        m_score  = 10;
        m_streak = 1;
    endtask

    task automatic test_miss();
        tick(1'b1, 8'h01);
        ticks(10);
        sb.push_back('{4'b0000, 4'b0001, 16'd10, 8'd0, 3'd1});
        ticks(1);
        m_streak = 0;
    endtask

    task automatic test_multiplier();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        total++;
        if (bus.score !== 16'd0 || bus.streak !== 8'd0 || bus.multiplier !== 3'd1) begin
            bad++;
            $display("FAIL clear got score=%0d streak=%0d mult=%0d want 0/0/1",
                     bus.score, bus.streak, bus.multiplier);
        end
        m_score  = 0;
        m_streak = 0;
        for (int k = 1; k <= 32; k++) begin
            int mp;
            mp = 1 + m_streak / 10;
            if (mp > 4) mp = 4;
            m_score  += 10 * mp;
            m_streak += 1;
            mp = 1 + m_streak / 10;
            if (mp > 4) mp = 4;
            tick(1'b1, 8'hC0);
            ticks(8);
            sb.push_back('{4'b1000, 4'b0000, 16'(m_score), 8'(m_streak), 3'(mp)});
            press(4'b1000, 1'b0);
            if (k == 10) begin
                total++;
                if (bus.multiplier !== 3'd2 || bus.score !== 16'd100) begin
                    bad++;
                    $display("FAIL mult_10 got mult=%0d score=%0d want 2/100", bus.multiplier, bus.score);
                end
            end
            if (k == 11) begin
                total++;
                if (bus.score !== 16'd120) begin
                    bad++;
                    $display("FAIL score_11 got %0d want 120", bus.score);
                end
            end
            if (k == 30 || k == 32) begin
                total++;
                if (bus.multiplier !== 3'd4) begin
                    bad++;
                    $display("FAIL mult_cap at hit %0d got %0d want 4", k, bus.multiplier);
                end
            end
        end
    endtask

    task automatic test_chord();
        // score 680, streak 32, x4 on entry
        tick(1'b1, 8'hFF);
        ticks(8);
        sb.push_back('{4'hF, 4'h0, 16'd840, 8'd36, 3'd4});
        press(4'hF, 1'b1);
        // green left unpressed at the last zone row exits on the same tick
        tick(1'b1, 8'hFF);
        ticks(10);
        sb.push_back('{4'b0111, 4'b1000, 16'd870, 8'd3, 3'd1});
        press(4'b0111, 1'b1);
    endtask

    task automatic test_stray();
        // yellow one row short of the zone: press is a stray
        tick(1'b1, 8'h30);
        ticks(7);
`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
        sb.push_back('{4'b0000, 4'b0100, 16'd870, 8'd0, 3'd1});
`endif
        press(4'b0100, 1'b0);
        total++;
        if (bus.score !== 16'd870 || bus.streak !== (PEN ? 8'd0 : 8'd3)) begin
            bad++;
            $display("FAIL stray_early got score=%0d streak=%0d want 870/%0d",
                     bus.score, bus.streak, PEN ? 0 : 3);
        end
        ticks(1);
        sb.push_back('{4'b0100, 4'b0000, 16'd880, PEN ? 8'd1 : 8'd4, 3'd1});
        press(4'b0100, 1'b0);
        // blue with an empty zone
`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
        sb.push_back('{4'b0000, 4'b0010, 16'd880, 8'd0, 3'd1});
`endif
        press(4'b0010, 1'b0);
        total++;
        if (bus.score !== 16'd880 || bus.streak !== (PEN ? 8'd0 : 8'd4)) begin
            bad++;
            $display("FAIL stray_empty got score=%0d streak=%0d want 880/%0d",
                     bus.score, bus.streak, PEN ? 0 : 4);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'hC0);
        ticks(8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.score, bus.streak, bus.multiplier, bus.hit_pulse, bus.miss_pulse} !==
            {16'd0, 8'd0, 3'd1, 4'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_async got score=%0d streak=%0d mult=%0d hit=%b miss=%b want 0/0/1/0/0",
                     bus.score, bus.streak, bus.multiplier, bus.hit_pulse, bus.miss_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // the green note that was in the zone must be gone
`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
        sb.push_back('{4'b0000, 4'b1000, 16'd0, 8'd0, 3'd1});
`endif
        press(4'b1000, 1'b0);
        total++;
        if (bus.score !== 16'd0 || bus.streak !== 8'd0) begin
            bad++;
            $display("FAIL reset_pipes got score=%0d streak=%0d want 0/0", bus.score, bus.streak);
        end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_single_hit();
                test_miss();
                test_multiplier();
                test_chord();
                test_stray();
                test_reset_mid();
                repeat (5) @(negedge clk);
                drv_done = 1'b1;
            end
            begin
                exp_t e;
                while (!drv_done && budget > 0) begin
                    @(negedge clk);
                    budget--;
                    if (bus.hit_pulse !== 4'h0 || bus.miss_pulse !== 4'h0) begin
                        total++;
                        if (sb.size() == 0) begin
                            bad++;
                            $display("FAIL pulse_unexpected got hit=%b miss=%b score=%0d streak=%0d",
                                     bus.hit_pulse, bus.miss_pulse, bus.score, bus.streak);
                        end else begin
                            e = sb.pop_front();
                            if ({bus.hit_pulse, bus.miss_pulse, bus.score, bus.streak, bus.multiplier} !==
                                {e.hit, e.miss, e.score, e.streak, e.mult}) begin
                                bad++;
                                $display("FAIL scoreboard got hit=%b miss=%b score=%0d streak=%0d mult=%0d want hit=%b miss=%b score=%0d streak=%0d mult=%0d",
                                         bus.hit_pulse, bus.miss_pulse, bus.score, bus.streak, bus.multiplier,
                                         e.hit, e.miss, e.score, e.streak, e.mult);
                            end
                        end
                    end
                end
                if (budget == 0) begin
                    total++;
                    bad++;
                    $display("FAIL timeout cycle budget expired");
                end
            end
        join
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Scoring stage directly downstream of the chart reader (read_8_bit_pattern) and the four lane buttons.
- Tracks every chart note from entry into the play field until it leaves the strike window. Judges each lane button press as a hit or a stray, and judges each note that passes unplayed as a miss.
- Produces score, streak and multiplier for screen_gen, plus per-lane hit/miss strobes for feedback.

Parameters:
- LEAD_ROWS, 8, chart ticks between a note entering and reaching the strike zone.
- HIT_WINDOW, 3, ticks a note stays hittable (zone positions LEAD_ROWS .. LEAD_ROWS+HIT_WINDOW-1).
- HIT_POINTS, 10, base points per hit.
- STREAK_STEP, 10, streak hits per multiplier step.
- MAX_MULT, 4, multiplier ceiling.

Ports:
- CLK  in  1  system clock (25.125 MHz)
- RESET_N  in  1  asynchronous active-low reset
- clear  in  1  synchronous song restart; same effect as reset
- note_tick  in  1  one-CLK strobe per chart row (derived from counter_clk edge)
- note  in  8  chart row: [7:6] green, [5:4] yellow, [3:2] blue, [1:0] orange; nonzero code = note
- note_valid  in  1  note is meaningful on this tick; 0 shifts in empty rows
- btn_n  in  4  {green, yellow, blue, orange} buttons, active-low, asynchronous
- score  out  16  saturating total
- streak  out  8  consecutive hits, saturates at 255
- multiplier  out  3  1..MAX_MULT
- hit_pulse  out  4  per-lane one-CLK hit strobe
- miss_pulse  out  4  per-lane one-CLK miss strobe

Behaviour:
- Reset (async) or clear (sync): score=0, streak=0, multiplier=1, pulses=0, lane pipes empty, synchronizers set to released (1).
- Buttons: 2-FF synchronizer, then falling-edge detect on the sync output. A press is a 1→0 transition.
- Lane pipe: one bit per lane, depth D = LEAD_ROWS + HIT_WINDOW.
  - On note_tick, shift by one. Bit 0 = note_valid && (lane code != 0).
- Miss on tick: a set bit shifted out of position D-1 raises miss_pulse[lane].
- Press: judged against the pipe contents before any same-cycle shift.
  - If any zone bit is set, clear the oldest one (highest index) and raise hit_pulse[lane].
  - Otherwise the press is a stray: no pulse, no score change.
- Same-cycle press and tick:
  - The hit bit is cleared and the shift is applied together.
  - A bit that was hit never produces a miss.
- Judgement to strobe/output latency: 1 CLK. All outputs are registered.
- Per-cycle update, with H = hits this cycle (0..4):
  - If any miss occurs: streak=0 first, then the hits are applied with the multiplier recomputed from streak 0.
  - Otherwise streak += H, saturating at 255.
  - score += H × HIT_POINTS × mult, where mult is computed from the streak before adding H. Score saturates at 16'hFFFF.
  - multiplier = min(1 + streak/STREAK_STEP, MAX_MULT), recomputed from the new streak and registered with it.
- Arithmetic: sums are formed at 18 bits, then clamped to the output width.
- clear takes priority over every same-cycle event.

Optional Feature:
- NOTE_JUDGE_STRAY_PENALTY_EN defined: a stray press resets streak to 0 (multiplier returns to 1). A stray raises miss_pulse[lane] for that lane.
- NOTE_JUDGE_STRAY_PENALTY_EN undefined: strays are ignored entirely.

Test Plan:
- Reset values: assert RESET_N=0 mid-song → outputs immediately 0/0/1/0/0. After release with no ticks: pipes empty and presses give no pulses.
- Single hit: green note (8'hC0) with note_valid; LEAD_ROWS=8 ticks later press green → hit_pulse=4'b1000 after 1 CLK, score=10, streak=1.
- Miss: orange note (8'h01); 11 ticks, no press → miss_pulse=4'b0001 on the 11th tick, streak resets to 0.
- Multiplier: 10 consecutive hits → multiplier=2 and score=100. The 11th hit adds 20 (score=120). After 30 hits multiplier=4, and it never exceeds 4.
- Simultaneous: chord 8'hFF in zone, all four pressed in the same CLK as a tick → hit_pulse=4'hF, streak+4, no misses. Same setup with green unpressed as its note exits → streak=0, then 3 hits at ×1.
- Stray/feature: press blue with an empty zone → no change. With NOTE_JUDGE_STRAY_PENALTY_EN → streak=0 and miss_pulse=4'b0010.
